// File: rtl/bitty_bridge_pkg.sv
// Shared types and helpers for the bitty UART bridge: dispatcher states,
// the result fill used on a watchdog expiry, and an index-width helper.
package bitty_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SEND      = 3'd3,
        ST_SEND_WAIT = 3'd4
    } disp_state_e;

    // Replicated per result byte, so any RESULT_BYTES gets an all-ones word.
    localparam logic [7:0] TIMEOUT_FILL_BYTE = 8'hFF;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bitty_sync_fifo.sv
// Registered synchronous FIFO with wrap-around pointers (extra MSB for full/empty).
// A push while full is accepted only when a pop happens in the same cycle.
module bitty_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW:0]                 rd_ptr_q, rd_ptr_d;
    logic                        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/bitty_uart_bridge.sv
// UART front end for the bitty core: assembles rx bytes into instruction words,
// queues them, dispatches one at a time and returns the result LSB-first over tx.
module bitty_uart_bridge
    import bitty_bridge_pkg::*;
#(
    parameter int INSTR_BYTES    = 2,
    parameter int RESULT_BYTES   = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_done,
    input  logic                      tx_done,
    output logic [7:0]                tx_data,
    output logic                      tx_en,
    output logic [8*INSTR_BYTES-1:0]  core_instr,
    output logic                      core_run,
    input  logic [8*RESULT_BYTES-1:0] core_out,
    input  logic                      core_done,
    output logic                      busy,
    output logic                      overflow,
    output logic                      timeout
);

    localparam int IW  = 8 * INSTR_BYTES;
    localparam int RW  = 8 * RESULT_BYTES;
    localparam int BCW = idx_width(INSTR_BYTES);
    localparam int BIW = idx_width(RESULT_BYTES);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]  word_q, word_d, push_word;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IW-1:0]  fifo_rdata;
    logic           overflow_q, overflow_d;

    disp_state_e    state_q, state_d;
    logic [IW-1:0]  instr_q, instr_d;
    logic [RW-1:0]  result_q, result_d;
    logic [BIW-1:0] byte_idx_q, byte_idx_d;
    logic [TW-1:0]  wdog_q, wdog_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           timeout_q, timeout_d;

    bitty_sync_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (push_word),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The final byte is merged combinationally so the word is pushed in its arrival cycle.
    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        push_word  = word_q;
        fifo_push  = 1'b0;
        if (rx_done) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                if (byte_cnt_q == BCW'(i)) push_word[i*8 +: 8] = rx_data;
            end
            word_d = push_word;
            if (byte_cnt_q == BCW'(INSTR_BYTES - 1)) begin
                byte_cnt_d = '0;
                fifo_push  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end
        overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        result_d   = result_q;
        byte_idx_d = byte_idx_q;
        wdog_d     = wdog_q;
        timeout_d  = timeout_q;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        core_run   = 1'b0;
        tx_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    instr_d  = fifo_rdata;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                core_run = 1'b1;
                wdog_d   = '0;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    result_d   = core_out;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    result_d   = {RESULT_BYTES{TIMEOUT_FILL_BYTE}};
                    timeout_d  = 1'b1;
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_SEND: begin
                tx_en   = 1'b1;
                state_d = ST_SEND_WAIT;
            end
            ST_SEND_WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q == BIW'(RESULT_BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // tx_data is loaded on entry to SEND so it is valid with tx_en and holds afterwards.
        if (state_d == ST_SEND && state_q != ST_SEND) begin
            for (int i = 0; i < RESULT_BYTES; i++) begin
                if (byte_idx_d == BIW'(i)) tx_data_d = result_d[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            result_q   <= '0;
            byte_idx_q <= '0;
            wdog_q     <= '0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            instr_q    <= instr_d;
            result_q   <= result_d;
            byte_idx_q <= byte_idx_d;
            wdog_q     <= wdog_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign core_instr = instr_q;
    assign busy       = (state_q != ST_IDLE);
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_bitty_uart_bridge.sv
// Directed bench for bitty_uart_bridge: a table of single-instruction vectors
// followed by hand-written streaming, overflow, watchdog, full push/pop and reset sequences.
module tb_bitty_uart_bridge;

    localparam int TIMEOUT_CYCLES = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic [15:0] core_instr;
    logic        core_run;
    logic [15:0] core_out = '0;
    logic        core_done = 1'b0;
    logic        busy, overflow, timeout;

    bitty_uart_bridge #(
        .INSTR_BYTES    (2),
        .RESULT_BYTES   (2),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .core_instr (core_instr),
        .core_run   (core_run),
        .core_out   (core_out),
        .core_done  (core_done),
        .busy       (busy),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Behaviour knobs for the core and transmitter models, set by the main sequence.
    logic [15:0] core_val;
    int          core_dly;
    int          tx_lat;
    logic [15:0] no_resp_instr;

    logic [15:0] run_q[$];
    int          run_cyc_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          pulse_err = 0;
    logic        run_prev = 1'b0;
    logic        tx_prev = 1'b0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (core_run) begin
                run_q.push_back(core_instr);
                run_cyc_q.push_back(cyc);
                if (run_prev) pulse_err <= pulse_err + 1;
            end
            if (tx_en) begin
                tx_q.push_back(tx_data);
                tx_cyc_q.push_back(cyc);
                if (tx_prev) pulse_err <= pulse_err + 1;
            end
        end
        run_prev <= core_run;
        tx_prev  <= tx_en;
    end

    int core_cnt = 0;
    always @(negedge clk) begin
        core_done <= 1'b0;
        if (reset_n === 1'b1 && core_run && core_instr != no_resp_instr) begin
            core_cnt <= core_dly;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done <= 1'b1;
                core_out  <= core_val;
            end
        end
    end

    // Deliberately not cleared by reset: a late tx_done must be ignored by the DUT.
    int tx_cnt = 0;
    always @(negedge clk) begin
        tx_done <= 1'b0;
        if (tx_en) begin
            tx_cnt <= tx_lat;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_done <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] run_at(input int i);
        return (i < run_q.size()) ? run_q[i] : 16'hxxxx;
    endfunction

    function automatic logic [7:0] tx_at(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_instr(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    // Quiet means the dispatcher stayed in IDLE long enough that the FIFO must be empty.
    task automatic wait_quiet(input string name, input int max_cyc);
        int idle;
        idle = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) idle = 0;
            else idle++;
            if (idle >= 4) break;
        end
        check({name, "_quiet"}, 32'(idle >= 4), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_overflow_clr", 32'(overflow), 32'd0);
        check("reset_timeout_clr", 32'(timeout), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] res;
        int          dly;
        logic [15:0] exp_instr;
        logic [7:0]  exp_tx0;
        logic [7:0]  exp_tx1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int rb, tb, idle_seen;
        vecs[0] = '{8'h34, 8'h12, 16'hBEEF, 5,  16'h1234, 8'hEF, 8'hBE};
        vecs[1] = '{8'hFF, 8'h00, 16'h0001, 1,  16'h00FF, 8'h01, 8'h00};
        vecs[2] = '{8'h00, 8'hA5, 16'h8000, 12, 16'hA500, 8'h00, 8'h80};
        vecs[3] = '{8'h5A, 8'hC3, 16'h7E81, 2,  16'hC35A, 8'h81, 8'h7E};

        reset_n       = 1'b0;
        rx_data       = '0;
        rx_done       = 1'b0;
        core_val      = '0;
        core_dly      = 5;
        tx_lat        = 3;
        no_resp_instr = 16'hDEAD;

        repeat (3) @(negedge clk);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_core_instr", 32'(core_instr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            rb = run_q.size();
            tb = tx_q.size();
            core_val = vecs[k].res;
            core_dly = vecs[k].dly;
            send_byte(vecs[k].b0);
            send_byte(vecs[k].b1);
            wait_quiet($sformatf("vec%0d", k), 400);
            check($sformatf("vec%0d_runs", k), 32'(run_q.size() - rb), 32'd1);
            check($sformatf("vec%0d_instr", k), 32'(run_at(rb)), 32'(vecs[k].exp_instr));
            check($sformatf("vec%0d_txcnt", k), 32'(tx_q.size() - tb), 32'd2);
            check($sformatf("vec%0d_tx0", k), 32'(tx_at(tb)), 32'(vecs[k].exp_tx0));
            check($sformatf("vec%0d_tx1", k), 32'(tx_at(tb + 1)), 32'(vecs[k].exp_tx1));
            check($sformatf("vec%0d_busy", k), 32'(busy), 32'd0);
        end

        // Streaming: all three words arrive while the first is still running.
        rb = run_q.size();
        tb = tx_q.size();
        core_dly = 50;
        send_instr(16'h0001);
        send_instr(16'h0002);
        send_instr(16'h0003);
        wait_quiet("stream", 800);
        check("stream_runs", 32'(run_q.size() - rb), 32'd3);
        check("stream_i0", 32'(run_at(rb)), 32'h0001);
        check("stream_i1", 32'(run_at(rb + 1)), 32'h0002);
        check("stream_i2", 32'(run_at(rb + 2)), 32'h0003);
        check("stream_txcnt", 32'(tx_q.size() - tb), 32'd6);
        check("stream_overflow", 32'(overflow), 32'd0);

        // Overflow: one in flight, four queued, the sixth dropped.
        apply_reset();
        rb = run_q.size();
        core_dly = 100;
        for (int i = 1; i <= 6; i++) send_instr(16'h0010 + 16'(i));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        wait_quiet("ovf", 1500);
        check("ovf_runs", 32'(run_q.size() - rb), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("ovf_i%0d", i), 32'(run_at(rb + i)), 32'h0011 + 32'(i));

        // Watchdog: 0xDEAD never completes; the following word runs normally.
        apply_reset();
        rb = run_q.size();
        tb = tx_q.size();
        core_dly = 4;
        core_val = 16'h1357;
        send_instr(16'hDEAD);
        send_instr(16'h00BB);
        wait_quiet("wdog", 2000);
        check("wdog_runs", 32'(run_q.size() - rb), 32'd2);
        check("wdog_i0", 32'(run_at(rb)), 32'h0000DEAD);
        check("wdog_i1", 32'(run_at(rb + 1)), 32'h000000BB);
        check("wdog_txcnt", 32'(tx_q.size() - tb), 32'd4);
        check("wdog_tx0", 32'(tx_at(tb)), 32'hFF);
        check("wdog_tx1", 32'(tx_at(tb + 1)), 32'hFF);
        check("wdog_tx2", 32'(tx_at(tb + 2)), 32'h57);
        check("wdog_tx3", 32'(tx_at(tb + 3)), 32'h13);
        check("wdog_flag", 32'(timeout), 32'd1);
        // RUN cycle, then TIMEOUT_CYCLES cycles in WAIT_DONE, then SEND.
        if (run_cyc_q.size() > rb && tx_cyc_q.size() > tb)
            check("wdog_latency", 32'(tx_cyc_q[tb] - run_cyc_q[rb]), 32'(TIMEOUT_CYCLES + 1));
        else
            check("wdog_latency", 32'hFFFFFFFF, 32'(TIMEOUT_CYCLES + 1));

        // Full FIFO: the last byte of a sixth word lands in the IDLE pop cycle.
        apply_reset();
        rb = run_q.size();
        core_dly = 40;
        send_instr(16'h0A0A);
        send_instr(16'h0B0B);
        send_instr(16'h0C0C);
        send_instr(16'h0D0D);
        send_instr(16'h0E0E);
        send_byte(8'h0F);
        check("pp_overflow_pre", 32'(overflow), 32'd0);
        idle_seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_seen = 1;
                break;
            end
        end
        check("pp_idle_seen", 32'(idle_seen), 32'd1);
        rx_data = 8'h1F;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("pp_overflow", 32'(overflow), 32'd0);
        wait_quiet("pp", 1500);
        check("pp_runs", 32'(run_q.size() - rb), 32'd6);
        check("pp_i4", 32'(run_at(rb + 4)), 32'h0E0E);
        check("pp_i5", 32'(run_at(rb + 5)), 32'h1F0F);
        check("pp_overflow_end", 32'(overflow), 32'd0);

        // Reset between the two result bytes.
        rb = run_q.size();
        tb = tx_q.size();
        core_dly = 3;
        core_val = 16'hBEEF;
        tx_lat   = 6;
        send_instr(16'h4321);
        idle_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_q.size() > tb) begin
                idle_seen = 1;
                break;
            end
        end
        check("rs_first_byte", 32'(idle_seen), 32'd1);
        check("rs_first_val", 32'(tx_at(tb)), 32'hEF);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rs_tx_en", 32'(tx_en), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_overflow", 32'(overflow), 32'd0);
        check("rs_timeout", 32'(timeout), 32'd0);
        check("rs_core_run", 32'(core_run), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rs_no_stale", 32'(tx_q.size() - tb), 32'd1);
        check("rs_no_rerun", 32'(run_q.size() - rb), 32'd1);
        tx_lat   = 3;
        core_val = 16'h2468;
        send_byte(8'h00);
        send_byte(8'h80);
        wait_quiet("rs", 400);
        check("rs_fresh_instr", 32'(run_at(rb + 1)), 32'h8000);
        check("rs_fresh_tx0", 32'(tx_at(tb + 1)), 32'h68);
        check("rs_fresh_tx1", 32'(tx_at(tb + 2)), 32'h24);

        check("pulse_width", 32'(pulse_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not complete, limit 800000 ns");
        $fatal(1);
    end

endmodule

// File: doc/bitty_uart_bridge.md
Name: bitty_uart_bridge

Overview:
- Parametrised successor to the single-instruction UART front end for the bitty core.
- Assembles little-endian instruction words from the UART receive byte stream and queues them in an instruction FIFO, so the host may stream instructions while the core runs.
- Dispatches each queued instruction to the core, waits for done with a watchdog, and serialises the result LSB-first to the UART transmitter.
- Sits between the UART rx/tx modules and the core; the core is an external port group, not instantiated inside.

Parameters:
- INSTR_BYTES, 2: bytes per instruction word; instruction width IW = 8*INSTR_BYTES.
- RESULT_BYTES, 2: bytes per result word; result width RW = 8*RESULT_BYTES.
- FIFO_DEPTH, 4: instruction FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 1024: core watchdog limit, in cycles after core_run.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid in the cycle rx_done=1.
- rx_done  in  1  one-cycle strobe, one per received byte.
- tx_done  in  1  one-cycle strobe, transmitter finished the current byte.
- tx_data  out  8  byte to transmit.
- tx_en  out  1  one-cycle start pulse for the transmitter.
- core_instr  out  IW  instruction presented to the core.
- core_run  out  1  one-cycle start pulse to the core.
- core_out  in  RW  core result; sampled in the cycle core_done=1.
- core_done  in  1  core completion strobe.
- busy  out  1  high while the dispatcher is not in IDLE.
- overflow  out  1  sticky: an instruction was dropped because the FIFO was full.
- timeout  out  1  sticky: the watchdog expired at least once.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, byte counter 0, dispatcher in IDLE, sticky flags cleared. Reset mid-operation abandons any partial word, queue contents and in-flight result; it issues no further tx_en or core_run.
- Assembler:
  - Each rx_done writes rx_data into byte lane byte_cnt. Lane 0 is the LSB.
  - byte_cnt counts 0..INSTR_BYTES-1 and wraps to 0.
  - On the final byte the complete word is pushed in the same cycle.
  - Push into a full FIFO: the word is discarded, overflow is set, byte_cnt still wraps. Framing stays aligned.
- FIFO:
  - Synchronous and registered; pointers are wrap-around with an extra MSB, giving full/empty.
  - A simultaneous push and pop while full is legal: the pop frees a slot, the push is accepted, and overflow is not set.
  - Push-to-pop latency is 1 cycle minimum, so a word is seen as non-empty the cycle after its push.
- Dispatcher states: IDLE, RUN, WAIT_DONE, SEND, SEND_WAIT.
  - IDLE: when the FIFO is not empty, pop the head into core_instr and go to RUN.
  - RUN: core_run=1 for exactly one cycle, clear the watchdog, go to WAIT_DONE. core_instr holds stable until the next pop.
  - WAIT_DONE:
    - On core_done, latch core_out into the result register, set byte_idx=0, go to SEND.
    - If the watchdog reaches TIMEOUT_CYCLES-1 with no done, load all-ones into the result register, set timeout, go to SEND.
    - If core_done and expiry coincide, core_done wins.
  - SEND: tx_data = result byte byte_idx, tx_en=1 for one cycle, go to SEND_WAIT.
  - SEND_WAIT:
    - On tx_done with byte_idx=RESULT_BYTES-1, go to IDLE.
    - Otherwise byte_idx++ and go to SEND.
    - tx_data holds the current byte until the next SEND.
- core_done or tx_done arriving outside their wait states is ignored.
- Assembler and FIFO push keep running in every dispatcher state.
- Back-to-back: from IDLE with the FIFO non-empty, the next core_run follows 2 cycles after the last tx_done.

Decomposition:
- Package bitty_bridge_pkg holds:
  - dispatcher state enum (logic [2:0]);
  - TIMEOUT fill constant (all-ones);
  - byte-index width helper function ($clog2 wrapper, minimum 1).
- One sub-module, bitty_sync_fifo (WIDTH, DEPTH; push, pop, wdata, rdata, full, empty). It is reusable by the future tx-side queue.

Test Plan:
- Single instruction: rx bytes 0x34, 0x12 -> one core_run with core_instr=0x1234. Core returns 0xBEEF after 5 cycles -> tx_en pulses with tx_data 0xEF then 0xBE, one pulse per tx_done, then busy=0.
- Streaming: send 3 instructions (6 bytes) while the core stalls 50 cycles on each -> three core_run pulses in order 0x0001, 0x0002, 0x0003. overflow stays 0.
- Overflow (FIFO_DEPTH=4): core stalled, send 6 instructions -> the first is dispatched, the next 4 are queued, the 6th is dropped. overflow=1; the subsequent 5 dispatched instrs are the first five sent.
- Watchdog: core_done never asserted -> after TIMEOUT_CYCLES the bytes 0xFF, 0xFF are sent and timeout=1. The next queued instruction then dispatches normally.
- Simultaneous full push/pop: FIFO full, final rx byte arrives in the same cycle as the IDLE pop -> the word is accepted and overflow stays 0.
- Reset mid-send: assert reset_n=0 between the two tx bytes -> tx_en, busy and the flags are 0. After release, no stale byte is sent, and a fresh 0x00, 0x80 is dispatched as 0x8000.
